// File: rtl/keypad_hex_entry.sv
// 4x4 hex keypad scanner: drives one column low at a time, samples the
// synchronized rows at the end of each column period, debounces the full
// 16-bit matrix snapshot and shifts each accepted key code into a 16-bit word.
module keypad_hex_entry #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [15:0] data,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_BLOCKED
    } state_t;

    logic [3:0]       r_row_meta;
    logic [3:0]       r_row_sync;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col_idx;
    logic [11:0]      r_snap;
    logic [15:0]      r_raw;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [15:0]      r_stable;
    logic             r_stable_upd;
    state_t           r_state;
    logic [15:0]      r_data;
    logic             r_key_valid;
    logic [3:0]       r_key_code;
    logic             r_key_held;

    logic [3:0]       w_rows;
    logic             w_col_end;
    logic             w_scan_end;
    logic [15:0]      w_snapshot;
    logic [DEB_W-1:0] w_deb_next;
    logic             w_none;
    logic             w_one;
    logic [3:0]       w_code;

    assign w_rows     = ~r_row_sync;
    assign w_col_end  = (r_div == DIV_LAST);
    assign w_scan_end = w_col_end && (r_col_idx == 2'd3);
    // Column 3 rows complete the snapshot on the cycle they are sampled.
    assign w_snapshot = {w_rows, r_snap};

    assign COL       = ~(4'b0001 << r_col_idx);
    assign data      = r_data;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign key_held  = r_key_held;

    // Two-flop synchronizer for the asynchronous row inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // Rows idle high (pull-ups), so reset to "nothing pressed".
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of its source.
            r_row_meta <= ROW;
            r_row_sync <= r_row_meta;
        end
    end

    // Column divider and column index.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_div     <= '0;
            r_col_idx <= 2'd0;
        end else if (w_col_end) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Next debounce count for the snapshot completing this cycle.
    always_comb begin
        // NOTE: a default before any branch keeps combinational logic latch-free.
        w_deb_next = r_deb_cnt;
        if (w_snapshot != r_raw) begin
            w_deb_next = DEB_W'(1);
        end else if (r_deb_cnt != DEB_MAX) begin
            w_deb_next = r_deb_cnt + 1'b1;
        end
    end

    // Snapshot assembly, debounce counting and stable-snapshot capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_snap       <= '0;
            r_raw        <= '0;
            r_deb_cnt    <= '0;
            r_stable     <= '0;
            r_stable_upd <= 1'b0;
        end else begin
            r_stable_upd <= 1'b0;
            if (w_col_end) begin
                case (r_col_idx)
                    2'd0:    r_snap[3:0]  <= w_rows;
                    2'd1:    r_snap[7:4]  <= w_rows;
                    2'd2:    r_snap[11:8] <= w_rows;
                    default: ;
                endcase
            end
            if (w_scan_end) begin
                r_raw     <= w_snapshot;
                r_deb_cnt <= w_deb_next;
                if (w_deb_next == DEB_MAX) begin
                    r_stable     <= w_snapshot;
                    r_stable_upd <= 1'b1;
                end
            end
        end
    end

    // Population classification and key code of the stable snapshot.
    // Snapshot bit 4c+r maps to key code 4r+c, i.e. the two nibble halves swap.
    always_comb begin
        w_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (r_stable[i]) begin
                w_code = {i[1:0], i[3:2]};
            end
        end
    end

    assign w_none = (r_stable == 16'h0000);
    assign w_one  = !w_none && ((r_stable & (r_stable - 16'd1)) == 16'h0000);

    // Key acceptance FSM with registered outputs; advances only on stable updates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_data      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (r_stable_upd) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_one) begin
                            r_state     <= S_PRESSED;
                            r_key_valid <= 1'b1;
                            r_key_code  <= w_code;
                            r_data      <= {r_data[11:0], w_code};
                            r_key_held  <= 1'b1;
                        end else if (!w_none) begin
                            r_state <= S_BLOCKED;
                        end
                    end
                    S_PRESSED: begin
                        if (w_none) begin
                            r_state    <= S_IDLE;
                            r_key_held <= 1'b0;
                        end
                    end
                    S_BLOCKED: begin
                        if (w_none) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a behavioural 4x4 keypad matrix.
module tb_keypad_hex_entry;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 2;
    localparam int SCAN_CYC       = 4 * SCAN_DIV;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [15:0] data;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;

    // keys[4*r+c] = key at row r, column c is held
    logic [15:0] keys;

    int          checks;
    int          errors;
    int          pulses;
    int          inv_err;
    logic [3:0]  last_code;
    logic [15:0] prev_data;

    keypad_hex_entry #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ROW      (ROW),
        .COL      (COL),
        .data     (data),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_held (key_held)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && !COL[c]) ROW[r] = 1'b0;
            end
        end
    end

    // Pulse monitor and data-change invariant, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_data = data;
        end else begin
            if (key_valid) begin
                pulses++;
                last_code = key_code;
                if (data !== {prev_data[11:0], key_code}) inv_err++;
            end else if (data !== prev_data) begin
                inv_err++;
            end
            prev_data = data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 2 ns past the edge.
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic wait_scans(input int n);
        wait_cycles(n * SCAN_CYC);
    endtask

    initial begin
        logic [15:0] exp_data;
        logic [3:0]  exp_col;
        logic [3:0]  prev_col;
        int          base;
        bit          found;

        checks    = 0;
        errors    = 0;
        pulses    = 0;
        inv_err   = 0;
        last_code = 4'h0;
        keys      = 16'h0000;
        RST_N     = 1'b0;
        exp_data  = 16'h0000;

        // ---- reset, then asynchronous reset in the middle of a scan ----
        wait_cycles(3);
        RST_N = 1'b1;
        wait_cycles(9);
        #3;
        RST_N = 1'b0;
        #1;
        check("rst_col",   COL,       4'b1110);
        check("rst_data",  data,      16'h0000);
        check("rst_valid", key_valid, 1'b0);
        check("rst_held",  key_held,  1'b0);
        check("rst_code",  key_code,  4'h0);

        // ---- column stepping after release: 4 cycles per column ----
        wait_cycles(1);
        #1;
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            exp_col = ~(4'b0001 << ((k / 4) % 4));
            check($sformatf("col_step%0d", k), COL, exp_col);
            wait_cycles(1);
        end

        // ---- single key (r=1,c=2) -> code 6 ----
        base = pulses;
        keys[6] = 1'b1;
        wait_scans(10);
        check("single_pulses", pulses - base, 1);
        check("single_code",   last_code,     4'h6);
        check("single_data",   data,          16'h0006);
        check("single_held",   key_held,      1'b1);
        keys = 16'h0000;
        wait_cycles(1);
        check("single_held_after_release", key_held, 1'b1);
        wait_scans(4);
        check("single_held_cleared", key_held,      1'b0);
        check("single_no_repeat",    pulses - base, 1);

        // ---- digit entry 1..5 starting from a cleared word ----
        RST_N = 1'b0;
        wait_cycles(1);
        RST_N = 1'b1;
        exp_data = 16'h0000;
        for (int d = 1; d <= 5; d++) begin
            base = pulses;
            keys[d] = 1'b1;
            wait_scans(4);
            keys = 16'h0000;
            wait_scans(4);
            exp_data = {exp_data[11:0], 4'(d)};
            check($sformatf("digit%0d_data", d),   data,          exp_data);
            check($sformatf("digit%0d_pulses", d), pulses - base, 1);
            check($sformatf("digit%0d_code", d),   last_code,     4'(d));
        end

        // ---- bounce on (0,0): align toggling so column-0 samples alternate ----
        found    = 1'b0;
        prev_col = COL;
        for (int k = 0; k < 64 && !found; k++) begin
            wait_cycles(1);
            if (prev_col == 4'b1110 && COL == 4'b1101) found = 1'b1;
            prev_col = COL;
        end
        check("bounce_align", found, 1'b1);
        wait_cycles(13);
        base = pulses;
        for (int i = 0; i < 8; i++) begin
            keys[0] = (i % 2 == 0);
            wait_cycles(5);
        end
        check("bounce_no_pulse", pulses - base, 0);
        keys[0] = 1'b1;
        wait_scans(3);
        exp_data = {exp_data[11:0], 4'h0};
        check("bounce_pulses", pulses - base, 1);
        check("bounce_code",   last_code,     4'h0);
        check("bounce_data",   data,          exp_data);
        keys = 16'h0000;
        wait_scans(4);

        // ---- two keys (0,1)+(3,3): blocked until full release ----
        base = pulses;
        keys[1]  = 1'b1;
        keys[15] = 1'b1;
        wait_scans(4);
        check("two_keys_no_pulse", pulses - base, 0);
        check("two_keys_not_held", key_held,      1'b0);
        keys[15] = 1'b0;
        wait_scans(4);
        check("two_keys_partial_release", pulses - base, 0);
        keys = 16'h0000;
        wait_scans(4);
        check("two_keys_released", pulses - base, 0);
        check("two_keys_data",     data,          exp_data);
        keys[15] = 1'b1;
        wait_scans(4);
        exp_data = {exp_data[11:0], 4'hF};
        check("key_f_pulses", pulses - base, 1);
        check("key_f_code",   last_code,     4'hF);
        check("key_f_data",   data,          exp_data);
        keys = 16'h0000;
        wait_scans(4);

        // ---- one-scan glitch on (2,0) ----
        base = pulses;
        keys[8] = 1'b1;
        wait_cycles(SCAN_CYC);
        keys = 16'h0000;
        wait_scans(4);
        check("glitch_no_pulse", pulses - base, 0);
        check("glitch_not_held", key_held,      1'b0);
        check("glitch_data",     data,          exp_data);

        check("data_only_changes_on_valid", inv_err, 0);

        // ---- reset mid-debounce with a non-zero word ----
        keys[6] = 1'b1;
        wait_scans(1);
        #3;
        RST_N = 1'b0;
        #1;
        check("midrst_col",   COL,       4'b1110);
        check("midrst_data",  data,      16'h0000);
        check("midrst_valid", key_valid, 1'b0);
        check("midrst_held",  key_held,  1'b0);
        keys = 16'h0000;
        wait_cycles(2);
        RST_N = 1'b1;
        wait_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
